// File: rtl/fp_mul_normalize_round_if.sv
// Handshake and payload bundle for the single-precision multiply normalize/round back end.
interface fp_mul_normalize_round_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_product;
  logic [7:0]  in_exp_a;
  logic [7:0]  in_exp_b;
  logic        in_sign;
  logic        in_zero;
  logic        in_inf;
  logic        in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  modport slave (
    input  in_valid, in_product, in_exp_a, in_exp_b, in_sign, in_zero, in_inf, in_nan,
    input  out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );

  modport master (
    output in_valid, in_product, in_exp_a, in_exp_b, in_sign, in_zero, in_inf, in_nan,
    output out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/fp_mul_normalize_round.sv
// Two-stage FP32 multiply back end: S1 normalizes the 48-bit significand product,
// S2 rounds to nearest-even, handles overflow/flush-to-zero/specials and packs the result.
module fp_mul_normalize_round (
  input  logic                      clk,
  input  logic                      rst,
  fp_mul_normalize_round_if.slave   bus
);

  localparam int unsigned MANT_W = 23;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned SEXP_W = 10;
  localparam int unsigned RES_W  = 32;

  logic                     s1_valid_q, s1_valid_d;
  logic [MANT_W-1:0]        s1_mant_q, s1_mant_d;
  logic                     s1_guard_q, s1_guard_d;
  logic                     s1_sticky_q, s1_sticky_d;
  logic signed [SEXP_W-1:0] s1_exp_q, s1_exp_d;
  logic                     s1_sign_q, s1_sign_d;
  logic                     s1_zero_q, s1_zero_d;
  logic                     s1_inf_q, s1_inf_d;
  logic                     s1_nan_q, s1_nan_d;

  logic                     s2_valid_q, s2_valid_d;
  logic [RES_W-1:0]         result_q, result_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;
  logic                     inexact_q, inexact_d;

  logic                     s1_adv, s2_adv;
  logic                     incr;
  logic [MANT_W:0]          mant_sum;
  logic signed [SEXP_W-1:0] exp_r;

  always_comb begin
    s2_adv      = !s2_valid_q || bus.out_ready;
    s1_adv      = !s1_valid_q || s2_adv;

    s1_valid_d  = s1_valid_q;
    s1_mant_d   = s1_mant_q;
    s1_guard_d  = s1_guard_q;
    s1_sticky_d = s1_sticky_q;
    s1_exp_d    = s1_exp_q;
    s1_sign_d   = s1_sign_q;
    s1_zero_d   = s1_zero_q;
    s1_inf_d    = s1_inf_q;
    s1_nan_d    = s1_nan_q;

    s2_valid_d  = s2_valid_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    inexact_d   = inexact_q;

    // S1: pick the leading one (bit 47 or 46) and fold the tail into guard/sticky
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        if (bus.in_product[47]) begin
          s1_mant_d   = bus.in_product[46:24];
          s1_guard_d  = bus.in_product[23];
          s1_sticky_d = |bus.in_product[22:0];
          s1_exp_d    = {2'b00, bus.in_exp_a} + {2'b00, bus.in_exp_b} - SEXP_W'(126);
        end else begin
          s1_mant_d   = bus.in_product[45:23];
          s1_guard_d  = bus.in_product[22];
          s1_sticky_d = |bus.in_product[21:0];
          s1_exp_d    = {2'b00, bus.in_exp_a} + {2'b00, bus.in_exp_b} - SEXP_W'(127);
        end
        s1_sign_d = bus.in_sign;
        s1_zero_d = bus.in_zero;
        s1_inf_d  = bus.in_inf;
        s1_nan_d  = bus.in_nan;
      end
    end

    // S2: round-to-nearest-even; a carry out of the mantissa leaves it zero and bumps exp
    incr     = s1_guard_q && (s1_sticky_q || s1_mant_q[0]);
    mant_sum = {1'b0, s1_mant_q} + (MANT_W + 1)'(incr);
    exp_r    = s1_exp_q + SEXP_W'(mant_sum[MANT_W]);

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        inexact_d   = 1'b0;
        if (s1_nan_q || (s1_inf_q && s1_zero_q)) begin
          result_d = 32'h7FC0_0000;
        end else if (s1_inf_q) begin
          result_d = {s1_sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        end else if (s1_zero_q) begin
          result_d = {s1_sign_q, (RES_W - 1)'(0)};
        end else if (exp_r >= SEXP_W'(255)) begin
          result_d   = {s1_sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
          overflow_d = 1'b1;
          inexact_d  = 1'b1;
        end else if (exp_r <= SEXP_W'(0)) begin
          result_d    = {s1_sign_q, (RES_W - 1)'(0)};
          underflow_d = 1'b1;
          inexact_d   = 1'b1;
        end else begin
          result_d  = {s1_sign_q, exp_r[EXP_W-1:0], mant_sum[MANT_W-1:0]};
          inexact_d = s1_guard_q || s1_sticky_q;
        end
      end
    end
  end

  // Control and output registers carry the reset; pipeline data does not need one
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      inexact_q   <= inexact_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_mant_q   <= s1_mant_d;
    s1_guard_q  <= s1_guard_d;
    s1_sticky_q <= s1_sticky_d;
    s1_exp_q    <= s1_exp_d;
    s1_sign_q   <= s1_sign_d;
    s1_zero_q   <= s1_zero_d;
    s1_inf_q    <= s1_inf_d;
    s1_nan_q    <= s1_nan_d;
  end

  assign bus.in_ready      = s1_adv;
  assign bus.out_valid     = s2_valid_q;
  assign bus.out_result    = result_q;
  assign bus.out_overflow  = overflow_q;
  assign bus.out_underflow = underflow_q;
  assign bus.out_inexact   = inexact_q;

endmodule

// File: tb/tb_fp_mul_normalize_round.sv
// Bench for fp_mul_normalize_round: directed corner cases, back-pressure, reset and
// randomized streams scored against an integer-arithmetic rounding model.
module tb_fp_mul_normalize_round;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  fp_mul_normalize_round_if bus ();

  fp_mul_normalize_round dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] p;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic        s;
    logic        z;
    logic        i;
    logic        n;
    logic [34:0] exp;
  } vec_t;

  // Result as {result, overflow, underflow, inexact}, from the value of the product
  function automatic logic [34:0] model(input logic [47:0] p, input logic [7:0] ea,
                                        input logic [7:0] eb, input logic s, input logic z,
                                        input logic inf, input logic nan);
    longint unsigned keep, rem, half;
    int              sh, e;
    bit              up;
    if (nan || (inf && z)) return {32'h7FC0_0000, 3'b000};
    if (inf) return {s, 8'hFF, 23'h0, 3'b000};
    if (z) return {s, 31'h0, 3'b000};
    sh   = p[47] ? 24 : 23;
    e    = int'(ea) + int'(eb) - 127 + (p[47] ? 1 : 0);
    keep = 64'(p) >> sh;
    rem  = 64'(p) - (keep << sh);
    half = 64'(1) << (sh - 1);
    up   = (rem > half) || (rem == half && keep[0]);
    keep = keep + 64'(up);
    if (keep == (64'(1) << 24)) begin
      keep = 64'(1) << 23;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0, 3'b101};
    if (e <= 0) return {s, 31'h0, 3'b011};
    return {s, 8'(e), 23'(keep), 2'b00, (rem != 0)};
  endfunction

  function automatic logic [34:0] observed();
    return {bus.out_result, bus.out_overflow, bus.out_underflow, bus.out_inexact};
  endfunction

  task automatic drive_beat(input logic v, input logic [47:0] p, input logic [7:0] ea,
                            input logic [7:0] eb, input logic s, input logic z,
                            input logic i, input logic n);
    bus.in_valid   = v;
    bus.in_product = p;
    bus.in_exp_a   = ea;
    bus.in_exp_b   = eb;
    bus.in_sign    = s;
    bus.in_zero    = z;
    bus.in_inf     = i;
    bus.in_nan     = n;
  endtask

  task automatic drive_random(input logic v);
    logic [47:0] p;
    p = {$urandom(), $urandom()};
    p[47:46] = ($urandom_range(0, 1) == 1) ? {1'b1, p[46]} : 2'b01;
    if ($urandom_range(0, 3) == 0) p[22:0] = ($urandom_range(0, 1) == 1) ? 23'h40_0000 : 23'h0;
    drive_beat(v, p, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 23) == 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_beat(1'b0, 48'h0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    n_cmp++;
    if (observed() !== 35'h0) begin
      n_fail++; $display("FAIL reset_outputs got=%h want=0", observed());
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    vec_t vt[10];
    int   lat;
    vt[0] = '{48'h4000_0000_0000, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0, {32'h3F80_0000, 3'b000}};
    vt[1] = '{48'h9000_0000_0000, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0, {32'h4010_0000, 3'b000}};
    vt[2] = '{48'h4000_0040_0000, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0, {32'h3F80_0000, 3'b001}};
    vt[3] = '{48'h4000_00C0_0000, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0, {32'h3F80_0002, 3'b001}};
    vt[4] = '{48'h4000_0000_0000, 8'd254, 8'd254, 1'b0, 1'b0, 1'b0, 1'b0, {32'h7F80_0000, 3'b101}};
    vt[5] = '{48'h4000_0000_0000, 8'd1,   8'd1,   1'b0, 1'b0, 1'b0, 1'b0, {32'h0000_0000, 3'b011}};
    vt[6] = '{48'h4000_0000_0000, 8'd127, 8'd127, 1'b0, 1'b1, 1'b1, 1'b0, {32'h7FC0_0000, 3'b000}};
    vt[7] = '{48'h4000_0000_0000, 8'd127, 8'd127, 1'b1, 1'b0, 1'b1, 1'b0, {32'hFF80_0000, 3'b000}};
    vt[8] = '{48'h4000_0000_0000, 8'd127, 8'd127, 1'b1, 1'b1, 1'b0, 1'b0, {32'h8000_0000, 3'b000}};
    vt[9] = '{48'h7FFF_FFC0_0001, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0, {32'h4000_0000, 3'b001}};
    bus.out_ready = 1'b1;
    foreach (vt[k]) begin
      drive_beat(1'b1, vt[k].p, vt[k].ea, vt[k].eb, vt[k].s, vt[k].z, vt[k].i, vt[k].n);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL directed%0d_in_ready got=%b want=1", k, bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      n_cmp++;
      if (lat !== 2) begin
        n_fail++; $display("FAIL directed%0d_latency got=%0d want=2", k, lat);
      end
      n_cmp++;
      if (observed() !== vt[k].exp) begin
        n_fail++; $display("FAIL directed%0d_result got=%h want=%h", k, observed(), vt[k].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] bp_p[3];
    logic [34:0] q[$];
    logic [34:0] want, held;
    int          sent, got;
    bit          stalled;
    bp_p[0] = 48'h4000_0000_0000;
    bp_p[1] = 48'h9000_0000_0000;
    bp_p[2] = 48'h4000_00C0_0000;
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 20; c++) begin
      bus.out_ready = (c >= 4);
      if (sent < 3) drive_beat(1'b1, bp_p[sent], 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0);
      else bus.in_valid = 1'b0;
      #1;
      if (c == 2) begin
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
          n_fail++; $display("FAIL bp_in_ready_full got=%b want=0", bus.in_ready);
        end
      end
      if (stalled) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || observed() !== held) begin
          n_fail++; $display("FAIL bp_hold cyc=%0d got=%b/%h want=1/%h", c, bus.out_valid, observed(), held);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = observed();
      if (bus.out_valid && bus.out_ready) begin
        want = (q.size() > 0) ? q.pop_front() : 35'h7_FFFF_FFFF;
        got++;
        n_cmp++;
        if (observed() !== want) begin
          n_fail++; $display("FAIL bp_result%0d got=%h want=%h", got, observed(), want);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bp_p[sent], 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0));
        sent++;
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (got !== 3) begin
      n_fail++; $display("FAIL bp_count got=%0d want=3", got);
    end
  endtask

  task automatic test_reset_inflight();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_beat(1'b1, 48'h4000_0000_0000, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || observed() !== 35'h0) begin
      n_fail++; $display("FAIL rst_flush got=%b/%h want=0/0", bus.out_valid, observed());
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready);
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_ghost cyc=%0d got=%b want=0", c, bus.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [34:0] q[$];
    logic [34:0] want;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k < 6) drive_random(1'b1);
      else bus.in_valid = 1'b0;
      #1;
      if (k < 6) begin
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_in_ready%0d got=%b want=1", k, bus.in_ready);
        end
      end
      if (k >= 2 && k < 8) begin
        want = (q.size() > 0) ? q.pop_front() : 35'h7_FFFF_FFFF;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || observed() !== want) begin
          n_fail++; $display("FAIL b2b_out%0d got=%b/%h want=1/%h", k, bus.out_valid, observed(), want);
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.in_product, bus.in_exp_a, bus.in_exp_b, bus.in_sign,
                          bus.in_zero, bus.in_inf, bus.in_nan));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    logic [34:0] q[$];
    logic [34:0] want, held;
    bit          stalled;
    stalled = 1'b0; held = '0;
    for (int c = 0; c < 600; c++) begin
      drive_random($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || observed() !== held) begin
          n_fail++; $display("FAIL rand_hold cyc=%0d got=%h want=%h", c, observed(), held);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = observed();
      if (bus.out_valid && bus.out_ready) begin
        want = (q.size() > 0) ? q.pop_front() : 35'h7_FFFF_FFFF;
        n_cmp++;
        if (observed() !== want) begin
          n_fail++; $display("FAIL rand_result cyc=%0d got=%h want=%h", c, observed(), want);
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.in_product, bus.in_exp_a, bus.in_exp_b, bus.in_sign,
                          bus.in_zero, bus.in_inf, bus.in_nan));
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid) begin
        want = (q.size() > 0) ? q.pop_front() : 35'h7_FFFF_FFFF;
        n_cmp++;
        if (observed() !== want) begin
          n_fail++; $display("FAIL rand_drain got=%h want=%h", observed(), want);
        end
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (q.size() !== 0) begin
      n_fail++; $display("FAIL rand_lost got=%0d want=0", q.size());
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_inflight();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_normalize_round.md
FP_MUL_NORMALIZE_ROUND -- requirements
Module: fp_mul_normalize_round

Interface
REQ-001 SHALL have no parameters; the datapath is fixed to IEEE-754 single precision with a 48-bit mantissa product.
REQ-002 SHALL provide these ports, clock and reset first:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_product  in  48  unsigned product of the two 24-bit significands (hidden bit included).
- in_exp_a, in_exp_b  in  8 each  biased operand exponents.
- in_sign  in  1  result sign (sign_a XOR sign_b).
- in_zero, in_inf, in_nan  in  1 each  upstream unpack flags: any operand zero or denormal; any operand infinity; any operand NaN.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  32  packed single-precision result.
- out_overflow, out_underflow, out_inexact  out  1 each  exception flags, qualified by out_valid.

Function
REQ-003 SHALL use a two-stage pipeline (S1 normalize, S2 round/pack). Each stage has one valid bit; latency in_valid accept to out_valid is 2 cycles when there is no back-pressure.
REQ-004 Transfer occurs on valid&ready at a port. S2 advances when !s2_valid | out_ready. S1 advances when !s1_valid | S2 advances. in_ready = S1 advances (combinational).
REQ-005 While out_valid=1 and out_ready=0, out_result and all flags SHALL hold stable. No beat may be dropped or duplicated.
REQ-006 S1: if in_product[47]=1: mant=p[46:24], guard=p[23], sticky=|p[22:0], exp=ea+eb-126. Otherwise: mant=p[45:23], guard=p[22], sticky=|p[21:0], exp=ea+eb-127. Compute exp as signed 10-bit.
REQ-007 S2 rounding is round-to-nearest-even. Increment when guard & (sticky | mant[0]). inexact = guard | sticky.
REQ-008 If the increment carries out of 23 bits, mant becomes 0 and exp becomes exp+1.
REQ-009 Overflow: a post-round exp >= 255 gives a result of {sign, 8'hFF, 23'h0}, with overflow=1 and inexact=1.
REQ-010 Underflow: a post-round exp <= 0 gives {sign, 31'h0} (flush to zero, no denormals), with underflow=1 and inexact=1.
REQ-011 Special cases, in priority order; each sets overflow, underflow and inexact to 0:
- nan, or (inf & zero): result 32'h7FC00000.
- inf: result {sign, 8'hFF, 23'h0}.
- zero: result {sign, 31'h0}.
REQ-012 The special flags and sign SHALL be pipelined alongside the data through S1 and S2.
REQ-013 Simultaneous accept at the input and release at the output in the same cycle SHALL sustain one result per cycle.

Reset
REQ-014 When rst=1 at a clock edge, s1_valid and s2_valid SHALL clear to 0.
REQ-015 While rst=1, out_valid=0. Reset also zeroes out_result and all flags.
REQ-016 Reset mid-operation discards all in-flight beats. in_ready=1 on the first cycle after rst deasserts.
REQ-017 Data registers other than the outputs need no reset.

Verification
REQ-018 Bench SHALL cover these directed scenarios:
- 1.0*1.0 (exp 127/127, product 48'h4000_0000_0000, out_ready=1) -> result 32'h3F800000 two cycles after accept; no flags.
- 1.5*1.5 (exp 127/127, product 48'h9000_0000_0000) -> result 32'h40100000; no flags.
- Tie cases with exp 127/127: product 48'h4000_0040_0000 -> 32'h3F800000, inexact=1. Product 48'h4000_00C0_0000 -> 32'h3F800002, inexact=1.
- Overflow: exp 254/254, product 48'h4000_0000_0000 -> 32'h7F800000, overflow=1. Underflow: exp 1/1 -> 32'h00000000, underflow=1.
- Specials: inf&zero -> 32'h7FC00000. inf with sign=1 -> 32'hFF800000. zero with sign=1 -> 32'h80000000.
- Back-pressure and reset:
  - Three back-to-back beats with out_ready=0 for 4 cycles -> in_ready=0 after two beats, outputs stable; all three results emerge in order.
  - rst asserted with two beats in flight -> out_valid=0 next cycle; neither result ever appears.
